// File: rtl/quad_decoder.sv
// Quadrature decoder: per-phase synchronizer and run-length filter, then a
// two-state tracker that turns Gray-code steps into registered step pulses.
module quad_decoder #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clr_err,
  output logic       en,
  output logic       up_down,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN);

  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

  // Bit 1 is phase A, bit 0 is phase B throughout.
  logic [1:0]          a_sync_q, b_sync_q;
  logic [1:0]          smp;
  logic [1:0]          last_q, last_d;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][CW-1:0]  run_q, run_d;
  logic                stable;

  state_t              state_q, state_d;
  logic [1:0]          ref_q, ref_d;
  logic                en_q, en_d;
  logic                up_q, up_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                illegal;

  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  assign smp = {a_sync_q[1], b_sync_q[1]};

  // run_q counts consecutive identical samples, saturating at FILT_LEN; a
  // full run both commits the level and marks the phase as settled.
  always_comb begin
    last_d = smp;
    filt_d = filt_q;
    run_d  = run_q;
    for (int i = 0; i < 2; i++) begin
      if (smp[i] != last_q[i]) begin
        run_d[i] = CW'(1);
      end else if (run_q[i] != RUN_MAX) begin
        run_d[i] = run_q[i] + 1'b1;
      end
      if (run_d[i] == RUN_MAX) begin
        filt_d[i] = smp[i];
      end
    end
  end

  assign stable = (run_q[0] == RUN_MAX) && (run_q[1] == RUN_MAX);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    en_d    = 1'b0;
    up_d    = up_q;
    illegal = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (stable) begin
          ref_d   = filt_q;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (filt_q != ref_q) begin
          ref_d = filt_q;
          if ((filt_q ^ ref_q) == 2'b11) begin
            illegal = 1'b1;
          end else begin
            en_d = 1'b1;
            up_d = (filt_q == fwd_next(ref_q));
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // A clear coinciding with an illegal step leaves that one step counted.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_d     = illegal;
      err_cnt_d = illegal ? 8'd1 : 8'd0;
    end else if (illegal) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q  <= '0;
      b_sync_q  <= '0;
      last_q    <= '0;
      filt_q    <= '0;
      run_q     <= '0;
      state_q   <= ST_INIT;
      ref_q     <= '0;
      en_q      <= 1'b0;
      up_q      <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      a_sync_q  <= {a_sync_q[0], a_in};
      b_sync_q  <= {b_sync_q[0], b_in};
      last_q    <= last_d;
      filt_q    <= filt_d;
      run_q     <= run_d;
      state_q   <= state_d;
      ref_q     <= ref_d;
      en_q      <= en_d;
      up_q      <= up_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign en      = en_q;
  assign up_down = up_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
